// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
//
// Purpose: responder state enum, the default NOP word and the index-width helper.
// Ports: none (package).

package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Bits needed to index a memory of 'depth' words.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch and program-load bus between core/loader and responder
//
// Purpose: bundles the core fetch signals and the loader handshake.
// Signals:
//   ip_instr_addr      core -> mem  byte fetch address
//   op_instr           mem -> core  fetched instruction (NOP when invalid)
//   op_instr_valid     mem -> core  op_instr is a loaded program word
//   op_fetch_err       mem -> core  previous fetch was misaligned or out of range
//   op_instr_addr_echo mem -> core  address that produced op_instr
//   ip_load_data/valid loader -> mem program word stream
//   op_load_ready      mem -> loader word accepted this cycle
//   ip_load_done       loader -> mem program complete
//   ip_reload          loader -> mem drop program, return to loading
//   op_prog_len        mem -> loader number of words loaded
// Modports: master (core/loader side), slave (responder side).

interface imem_responder_if #(
  parameter int unsigned DEPTH = 256
);
  import imem_pkg::*;

  localparam int unsigned PW = idx_width(DEPTH) + 1;

  logic [31:0]   ip_instr_addr;
  logic [31:0]   op_instr;
  logic          op_instr_valid;
  logic          op_fetch_err;
  logic [31:0]   op_instr_addr_echo;
  logic [31:0]   ip_load_data;
  logic          ip_load_valid;
  logic          op_load_ready;
  logic          ip_load_done;
  logic          ip_reload;
  logic [PW-1:0] op_prog_len;

  modport master (
    output ip_instr_addr, ip_load_data, ip_load_valid, ip_load_done, ip_reload,
    input  op_instr, op_instr_valid, op_fetch_err, op_instr_addr_echo,
           op_load_ready, op_prog_len
  );

  modport slave (
    input  ip_instr_addr, ip_load_data, ip_load_valid, ip_load_done, ip_reload,
    output op_instr, op_instr_valid, op_fetch_err, op_instr_addr_echo,
           op_load_ready, op_prog_len
  );

endinterface

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x 32 program store, one write port, one registered read port
//
// Purpose: backing memory for the responder. Not reset; contents are only
// observable through the responder's prog_len gating.
// Ports:
//   clk        in  clock
//   i_wr_en    in  write strobe
//   i_wr_addr  in  write word index
//   i_wr_data  in  write data
//   i_rd_en    in  read strobe (read data updates only when set)
//   i_rd_addr  in  read word index
//   o_rd_data  out registered read data, one cycle after i_rd_en

module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - memory-side end of the core fetch interface with program loader
//
// Purpose: accepts a program over a ready/valid load stream (LOAD), then serves
// fetches with one-cycle registered latency (RUN). Misaligned or out-of-range
// fetches return NOP_INSTR with valid low and a one-cycle error pulse.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of imem_responder_if (fetch + load signals)
// Parameters: DEPTH (words, power of two >= 2), BASE_ADDR (byte address of
// word 0, 4-byte aligned), NOP_INSTR (word returned on invalid fetch).

module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);

  localparam int unsigned AW = idx_width(DEPTH);
  localparam int unsigned PW = AW + 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_load_ptr;
  logic [PW-1:0] r_prog_len;
  logic          r_good;
  logic          r_err;
  logic [31:0]   r_echo;

  logic          w_load_ready;
  logic          w_accept;
  logic [31:0]   w_idx;
  logic          w_fetch_good;
  logic          w_rd_en;
  logic [31:0]   w_rd_data;

  // Underflow of the subtraction is harmless: the >= BASE_ADDR term rejects it.
  assign w_idx        = (bus.ip_instr_addr - BASE_ADDR) >> 2;
  assign w_fetch_good = (bus.ip_instr_addr[1:0] == 2'b00) &&
                        (bus.ip_instr_addr >= BASE_ADDR) &&
                        (w_idx < 32'(r_prog_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_accept     = 1'b0;
    w_rd_en      = 1'b0;
    case (r_state)
      LOAD: begin
        w_load_ready = (r_load_ptr < PW'(DEPTH));
        w_accept     = bus.ip_load_valid && w_load_ready;
        if (bus.ip_load_done) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_rd_en = 1'b1;
        if (bus.ip_reload) begin
          w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_ptr <= '0;
      r_prog_len <= '0;
      r_good     <= 1'b0;
      r_err      <= 1'b0;
      r_echo     <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_good <= 1'b0;
          r_err  <= 1'b0;
          if (w_accept) begin
            r_load_ptr <= r_load_ptr + 1'b1;
          end
          // Count a word accepted alongside done.
          if (bus.ip_load_done) begin
            r_prog_len <= r_load_ptr + PW'(w_accept);
          end
        end
        RUN: begin
          r_echo <= bus.ip_instr_addr;
          if (bus.ip_reload) begin
            r_load_ptr <= '0;
            r_prog_len <= '0;
            r_good     <= 1'b0;
            r_err      <= 1'b0;
          end else begin
            r_good <= w_fetch_good;
            r_err  <= !w_fetch_good;
          end
        end
        default: begin
          r_good <= 1'b0;
          r_err  <= 1'b0;
        end
      endcase
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_load_ptr[AW-1:0]),
    .i_wr_data (bus.ip_load_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_idx[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // The good flag is registered alongside the RAM read, so it masks stale or
  // unloaded RAM data with NOP on the same cycle the data appears.
  assign bus.op_instr           = r_good ? w_rd_data : NOP_INSTR;
  assign bus.op_instr_valid     = r_good;
  assign bus.op_fetch_err       = r_err;
  assign bus.op_instr_addr_echo = r_echo;
  assign bus.op_load_ready      = w_load_ready;
  assign bus.op_prog_len        = r_prog_len;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder (DEPTH 256 and DEPTH 4)

module tb_imem_responder;
  import imem_pkg::*;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned D_BIG = 256;
  localparam int unsigned D_SML = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] s_addr, s_data;
  logic        s_valid, s_done, s_reload;

  imem_responder_if #(.DEPTH(D_BIG)) bus_big ();
  imem_responder_if #(.DEPTH(D_SML)) bus_sml ();

  assign bus_big.ip_instr_addr = s_addr;
  assign bus_big.ip_load_data  = s_data;
  assign bus_big.ip_load_valid = s_valid;
  assign bus_big.ip_load_done  = s_done;
  assign bus_big.ip_reload     = s_reload;
  assign bus_sml.ip_instr_addr = s_addr;
  assign bus_sml.ip_load_data  = s_data;
  assign bus_sml.ip_load_valid = s_valid;
  assign bus_sml.ip_load_done  = s_done;
  assign bus_sml.ip_reload     = s_reload;

  imem_responder #(.DEPTH(D_BIG)) u_big (.clk(clk), .rst(rst), .bus(bus_big));
  imem_responder #(.DEPTH(D_SML)) u_sml (.clk(clk), .rst(rst), .bus(bus_sml));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: program as an array plus a word count, per instance.
  int unsigned m_depth [2] = '{D_BIG, D_SML};
  logic [31:0] m_mem   [2][256];
  int unsigned m_cnt   [2];
  int unsigned m_plen  [2];
  bit          m_run   [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_echo  [2];
  bit          m_valid [2];
  bit          m_err   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_cnt[k] = 0; m_plen[k] = 0;
      m_instr[k] = NOP; m_valid[k] = 0; m_err[k] = 0; m_echo[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    if (!m_run[k]) begin
      if (s_valid && m_cnt[k] < m_depth[k]) begin
        m_mem[k][m_cnt[k]] = s_data;
        m_cnt[k]++;
      end
      if (s_done) begin
        m_plen[k] = m_cnt[k];
        m_run[k]  = 1;
      end
      m_instr[k] = NOP; m_valid[k] = 0; m_err[k] = 0;
    end else begin
      m_echo[k] = s_addr;
      if (s_reload) begin
        m_run[k] = 0; m_cnt[k] = 0; m_plen[k] = 0;
        m_instr[k] = NOP; m_valid[k] = 0; m_err[k] = 0;
      end else if (s_addr % 4 == 0 && s_addr / 4 < m_plen[k]) begin
        m_instr[k] = m_mem[k][s_addr / 4]; m_valid[k] = 1; m_err[k] = 0;
      end else begin
        m_instr[k] = NOP; m_valid[k] = 0; m_err[k] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input int k, input logic [31:0] instr, input logic valid, input logic err,
                     input logic [31:0] echo, input logic ready, input logic [31:0] plen);
    chk($sformatf("m%0d.instr", k), instr, m_instr[k]);
    chk($sformatf("m%0d.valid", k), 32'(valid), 32'(m_valid[k]));
    chk($sformatf("m%0d.err", k), 32'(err), 32'(m_err[k]));
    chk($sformatf("m%0d.echo", k), echo, m_echo[k]);
    chk($sformatf("m%0d.ready", k), 32'(ready), 32'(!m_run[k] && m_cnt[k] < m_depth[k]));
    chk($sformatf("m%0d.plen", k), plen, m_plen[k]);
  endtask

  always @(negedge clk) begin
    cmp(0, bus_big.op_instr, bus_big.op_instr_valid, bus_big.op_fetch_err,
        bus_big.op_instr_addr_echo, bus_big.op_load_ready, 32'(bus_big.op_prog_len));
    cmp(1, bus_sml.op_instr, bus_sml.op_instr_valid, bus_sml.op_fetch_err,
        bus_sml.op_instr_addr_echo, bus_sml.op_load_ready, 32'(bus_sml.op_prog_len));
  end

  // Present one cycle of inputs; returns at the next negedge with its results visible.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic v,
                      input logic dn, input logic rl);
    s_addr = a; s_data = d; s_valid = v; s_done = dn; s_reload = rl;
    @(negedge clk);
  endtask

  task automatic async_reset();
    #3;
    s_addr = 0; s_data = 0; s_valid = 0; s_done = 0; s_reload = 0;
    rst = 1'b1;
    model_reset();
    #1;
  endtask

  logic [31:0] prog [4] = '{32'h00500093, 32'h00308113, 32'h002081B3, 32'h40110233};
  logic [31:0] ovf  [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};

  initial begin
    model_reset();
    s_addr = 0; s_data = 0; s_valid = 0; s_done = 0; s_reload = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.instr", bus_big.op_instr, 32'h0000_0013);
    chk("rst.valid", 32'(bus_big.op_instr_valid), 32'd0);
    chk("rst.ready", 32'(bus_big.op_load_ready), 32'd1);
    chk("rst.plen", 32'(bus_big.op_prog_len), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) step(0, prog[i], 1'b1, (i == 3), 1'b0);
    chk("load.plen", 32'(bus_big.op_prog_len), 32'd4);
    chk("load.ready_run", 32'(bus_big.op_load_ready), 32'd0);

    step(0, 0, 0, 0, 0);  chk("f0", bus_big.op_instr, 32'h00500093);
    chk("f0.valid", 32'(bus_big.op_instr_valid), 32'd1);
    step(4, 0, 0, 0, 0);  chk("f4", bus_big.op_instr, 32'h00308113);
    step(8, 0, 0, 0, 0);  chk("f8", bus_big.op_instr, 32'h002081B3);
    step(12, 0, 0, 0, 0); chk("f12", bus_big.op_instr, 32'h40110233);
    chk("f12.sml", bus_sml.op_instr, 32'h40110233);

    step(16, 0, 0, 0, 0);
    chk("f16.instr", bus_big.op_instr, 32'h0000_0013);
    chk("f16.err", 32'(bus_big.op_fetch_err), 32'd1);
    chk("f16.echo", bus_big.op_instr_addr_echo, 32'd16);
    step(6, 0, 0, 0, 0);
    chk("f6.err", 32'(bus_big.op_fetch_err), 32'd1);
    chk("f6.valid", 32'(bus_big.op_instr_valid), 32'd0);
    chk("f6.echo", bus_big.op_instr_addr_echo, 32'd6);

    step(0, 0, 0, 0, 0);
    step(4, 0, 0, 0, 1);
    chk("rl.valid", 32'(bus_big.op_instr_valid), 32'd0);
    chk("rl.err", 32'(bus_big.op_fetch_err), 32'd0);
    chk("rl.instr", bus_big.op_instr, 32'h0000_0013);
    chk("rl.ready", 32'(bus_big.op_load_ready), 32'd1);
    step(0, 32'hDEADBEEF, 1, 1, 0);
    chk("rl.plen", 32'(bus_big.op_prog_len), 32'd1);
    step(0, 0, 0, 0, 0); chk("rl.f0", bus_big.op_instr, 32'hDEADBEEF);
    step(4, 0, 0, 0, 0); chk("rl.f4.err", 32'(bus_big.op_fetch_err), 32'd1);

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, ovf[i], 1'b1, 1'b0, 1'b0);
      if (i == 3) chk("ovf.sml_ready", 32'(bus_sml.op_load_ready), 32'd0);
    end
    step(0, 0, 0, 1, 0);
    chk("ovf.sml_plen", 32'(bus_sml.op_prog_len), 32'd4);
    chk("ovf.big_plen", 32'(bus_big.op_prog_len), 32'd5);
    step(12, 0, 0, 0, 0); chk("ovf.sml_f12", bus_sml.op_instr, 32'hA000_0003);
    step(16, 0, 0, 0, 0);
    chk("ovf.sml_f16.err", 32'(bus_sml.op_fetch_err), 32'd1);
    chk("ovf.big_f16", bus_big.op_instr, 32'hA000_0004);

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    chk("zero.plen", 32'(bus_big.op_prog_len), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("zero.err", 32'(bus_big.op_fetch_err), 32'd1);
    chk("zero.valid", 32'(bus_big.op_instr_valid), 32'd0);

    step(0, 0, 0, 0, 1);
    step(0, prog[0], 1, 1, 0);
    step(8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("arst.pre_valid", 32'(bus_big.op_instr_valid), 32'd1);
    async_reset();
    chk("arst.run.valid", 32'(bus_big.op_instr_valid), 32'd0);
    chk("arst.run.instr", bus_big.op_instr, 32'h0000_0013);
    chk("arst.run.echo", bus_big.op_instr_addr_echo, 32'd0);
    chk("arst.run.plen", 32'(bus_big.op_prog_len), 32'd0);
    chk("arst.run.ready", 32'(bus_big.op_load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    step(0, prog[1], 1, 0, 0);
    step(0, prog[2], 1, 0, 0);
    async_reset();
    chk("arst.load.ready", 32'(bus_big.op_load_ready), 32'd1);
    chk("arst.load.plen", 32'(bus_big.op_prog_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1, 0);
    chk("arst.done.plen", 32'(bus_big.op_prog_len), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("arst.f0.err", 32'(bus_big.op_fetch_err), 32'd1);
    step(0, 0, 0, 0, 0);

    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
